store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- FIFO store buffer between the MEM-stage store path and the data memory write port.
- Accepts byte-enabled stores from the pipeline and retires them to data memory one per cycle whenever the shared memory port is not needed by a load.
- Supplies per-byte forwarding of buffered store data to loads.
- Also drains completely on request (halt/syscall).

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
st_valid  input  1  store request from MEM stage
st_addr  input  32  store byte address; bits [31:2] select the word, [1:0] ignored
st_data  input  32  store data, already lane-aligned
st_be  input  4  byte enables; bit i = byte lane i (bits 8i+7:8i)
st_pc  input  32  PC of the store, carried through for the write trace
st_ready  output  1  buffer can accept a store this cycle
ld_valid  input  1  load in MEM this cycle; owns the memory port
ld_addr  input  32  load byte address; only bits [31:2] used
fwd_data  output  32  buffered bytes for ld_addr word
fwd_mask  output  4  lanes of fwd_data valid from the buffer
flush  input  1  drain request; blocks new stores
empty  output  1  no valid entries
count  output  PTR_W+1  number of valid entries
dm_we  output  1  write strobe to data memory
dm_addr  output  32  {head word address, 2'b00}
dm_wd  output  32  head entry data
dm_be  output  4  head entry byte enables
dm_pc  output  32  head entry PC

Behaviour:
- Storage
  - DEPTH entries of {word addr[29:0], data[31:0], be[3:0], pc[31:0], valid}.
  - Head pointer (rd_ptr), tail pointer (wr_ptr), count register.
  - Pointers wrap modulo DEPTH.
- Reset (sync, clk rising edge with reset=1)
  - rd_ptr=0, wr_ptr=0, count=0, all valid=0.
  - After reset: empty=1, count=0, st_ready=1, dm_we=0, fwd_mask=0, fwd_data=0.
  - dm_addr/dm_wd/dm_be/dm_pc are 0 whenever empty.
  - Entries in the buffer at reset are discarded, never written.
  - dm_we is forced 0 in any cycle with reset=1.
- Enqueue
  - st_ready = (count != DEPTH) && !flush.
  - On clk edge with st_valid && st_ready: write entry at wr_ptr, set valid, wr_ptr+1.
  - st_be==4'b0000 is accepted and stored; it retires with dm_be=0, i.e. no memory change.
  - st_valid while st_ready=0: store dropped, no state change. The pipeline must stall on !st_ready; the bench flags any drop.
- Drain
  - dm_we = !empty && !ld_valid && !reset.
  - dm_* are driven combinationally from the head entry.
  - On clk edge with dm_we=1: clear head valid, rd_ptr+1. Memory commits on the same edge, so retire latency is 1 cycle per entry.
  - Minimum enqueue-to-memory latency: 1 cycle (store accepted edge N, dm_we high in cycle N+1, committed edge N+1).
- Simultaneous events
  - Enqueue and drain on the same edge: count unchanged, both pointers advance.
  - When full, st_ready=0 even if a drain occurs that cycle; no same-cycle bypass.
- Flush
  - While flush=1, no enqueues; draining continues under the same ld_valid rule.
  - Software/control waits for empty=1.
  - flush with empty=1 has no effect.
- Load forwarding (combinational)
  - For each lane i, scan valid entries from oldest to youngest.
  - The youngest entry with matching word address and be[i]=1 supplies byte i.
  - fwd_mask[i]=1 if any such entry exists; otherwise fwd_data lane i = 0.
  - Head entry being drained this cycle is impossible, since ld_valid blocks drain.
  - A store arriving in the same cycle is not visible to forwarding.
- Illegal input
  - st_valid && ld_valid in the same cycle is illegal.
  - If it occurs, the store is enqueued per the normal rules and the load forwards only already-buffered data.
- Count/empty
  - empty = (count==0).
  - count saturates only by construction; it never exceeds DEPTH.

Test Plan:
- Reset then single store st_addr=0x0000_0010, st_data=0x1234_5678, st_be=4'hF, ld_valid=0 -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0x12345678, dm_be=F; following cycle empty=1, count=0.
- Fill (DEPTH=4) with ld_valid=1 held: 4 stores to 0x0,0x4,0x8,0xC -> count=4, st_ready=0; a 5th st_valid is dropped; release ld_valid -> four dm_we pulses in FIFO order, addresses 0x0,0x4,0x8,0xC.
- Forwarding merge with ld_valid=1: store 0x20 data 0xAABBCCDD be=0011, then store 0x22 data 0x11220000 be=1100, then load 0x20 -> fwd_mask=1111, fwd_data=0x1122CCDD. Second store 0x20 be=0001 data 0x000000EE -> fwd_data=0x1122CCEE.
- Simultaneous enqueue+drain: count=2, ld_valid=0, st_valid=1 for 3 cycles -> count stays 2, pointers wrap past DEPTH-1 with correct order; no entry lost or duplicated.
- Flush: count=3, flush=1, alternate ld_valid 1/0 -> st_ready=0 throughout, dm_we only in ld_valid=0 cycles, empty=1 after 3 drains.
- Reset mid-operation: count=3, assert reset for one cycle -> dm_we=0 that cycle, then empty=1, count=0, fwd_mask=0 for load to any previously buffered address.

Source files
------------

// File: rtl/store_buffer.sv
// Byte-enabled store FIFO between MEM-stage stores and the data-memory port, with per-byte load forwarding.
// Retires one entry per cycle, one cycle after enqueue at the earliest; st_ready drops when full or flushing, and draining stalls while ld_valid owns the port.
module store_buffer #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_be,
    input  logic [31:0]      st_pc,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic [31:0]      fwd_data,
    output logic [3:0]       fwd_mask,
    input  logic             flush,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wd,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_pc
);

    logic [29:0]      e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [3:0]       e_be   [DEPTH];
    logic [31:0]      e_pc   [DEPTH];
    logic [DEPTH-1:0] e_vld;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] idx;
    logic             enq;
    logic             deq;
    logic             unused_lsbs;

    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign empty    = (count == '0);
    // Full blocks acceptance even when a drain frees a slot this cycle.
    assign st_ready = (count != (PTR_W+1)'(DEPTH)) && !flush;
    assign enq      = st_valid && st_ready;
    assign dm_we    = !empty && !ld_valid && !reset;
    assign deq      = dm_we;

    always_comb begin
        dm_addr = '0;
        dm_wd   = '0;
        dm_be   = '0;
        dm_pc   = '0;
        if (!empty) begin
            dm_addr = {e_addr[rd_ptr], 2'b00};
            dm_wd   = e_data[rd_ptr];
            dm_be   = e_be[rd_ptr];
            dm_pc   = e_pc[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            e_vld  <= '0;
        end else begin
            // enq and deq never target the same slot: deq needs count>0, enq needs count<DEPTH.
            if (enq) begin
                e_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                e_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            e_addr[wr_ptr] <= st_addr[31:2];
            e_data[wr_ptr] <= st_data;
            e_be[wr_ptr]   <= st_be;
            e_pc[wr_ptr]   <= st_pc;
        end
    end

    // Oldest-to-youngest scan so younger matching bytes overwrite older ones.
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (e_vld[idx] && (e_addr[idx] == ld_addr[31:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (e_be[idx][i]) begin
                        fwd_data[8*i +: 8] = e_data[idx][8*i +: 8];
                        fwd_mask[i]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard of expected memory writes plus inline status checks.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;
    logic        flush;
    logic        empty;
    logic [2:0]  count;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] pc;
    } wr_t;

    wr_t sb[$];
    int  nvec = 0;
    int  nerr = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_be(st_be), .st_pc(st_pc), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .fwd_data(fwd_data), .fwd_mask(fwd_mask),
        .flush(flush), .empty(empty), .count(count),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_be(dm_be), .dm_pc(dm_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one store for one edge; st_valid is left high for the caller to clear.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] pc, input logic exp_rdy);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        st_pc    = pc;
        #2;
        chk("st_ready", 32'(st_ready), 32'(exp_rdy));
        if (exp_rdy)
            sb.push_back('{addr: {a[31:2], 2'b00}, wd: d, be: be, pc: pc});
        tick();
    endtask

    // Monitor: every memory write must match the oldest outstanding store.
    always @(negedge clk) begin
        if (dm_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_dm_we_addr", dm_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("dm_addr", dm_addr, e.addr);
                chk("dm_wd", dm_wd, e.wd);
                chk("dm_be", 32'(dm_be), 32'(e.be));
                chk("dm_pc", dm_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        st_pc = '0; ld_valid = 1'b0; ld_addr = '0; flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_fwd_mask", 32'(fwd_mask), 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        tick();

        // Single store retires the cycle after acceptance.
        store(32'h0000_0010, 32'h1234_5678, 4'hF, 32'h0000_0100, 1'b1);
        st_valid = 1'b0;
        #2;
        chk("single_dm_we", 32'(dm_we), 32'd1);
        chk("single_count", 32'(count), 32'd1);
        tick();
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_count0", 32'(count), 32'd0);

        // Fill behind a held load, drop a fifth store, then drain in order.
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++)
            store(32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 32'h200 + 32'(i * 4), 1'b1);
        chk("full_count", 32'(count), 32'd4);
        store(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0000_0210, 1'b0);
        st_valid = 1'b0;
        chk("full_count_after_drop", 32'(count), 32'd4);
        ld_valid = 1'b0;
        repeat (4) tick();
        chk("fill_drained", 32'(empty), 32'd1);

        // Per-byte forwarding merge, youngest byte wins.
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_0020;
        store(32'h0000_0020, 32'hAABB_CCDD, 4'b0011, 32'h0000_0300, 1'b1);
        store(32'h0000_0022, 32'h1122_0000, 4'b1100, 32'h0000_0304, 1'b1);
        st_valid = 1'b0;
        #2;
        chk("fwd_mask_merge", 32'(fwd_mask), 32'hF);
        chk("fwd_data_merge", fwd_data, 32'h1122_CCDD);
        store(32'h0000_0020, 32'h0000_00EE, 4'b0001, 32'h0000_0308, 1'b1);
        st_valid = 1'b0;
        #2;
        chk("fwd_data_young", fwd_data, 32'h1122_CCEE);
        ld_addr = 32'h0000_0024;
        #1;
        chk("fwd_mask_miss", 32'(fwd_mask), 32'h0);
        tick();
        ld_valid = 1'b0;
        repeat (3) tick();
        chk("fwd_drained", 32'(empty), 32'd1);

        // Simultaneous enqueue and drain keep count steady while pointers wrap.
        ld_valid = 1'b1;
        store(32'h0000_0100, 32'h0000_0001, 4'hF, 32'h0000_0400, 1'b1);
        store(32'h0000_0104, 32'h0000_0002, 4'h0, 32'h0000_0404, 1'b1);
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store(32'h0000_0108 + 32'(i * 4), 32'h0000_0003 + 32'(i), 4'h5,
                  32'h0000_0408 + 32'(i * 4), 1'b1);
            chk("simul_count", 32'(count), 32'd2);
        end
        st_valid = 1'b0;
        repeat (2) tick();
        chk("simul_drained", 32'(empty), 32'd1);

        // Flush: stores blocked, drains only when the port is free.
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++)
            store(32'h0000_0500 + 32'(i * 4), 32'h5500_0000 + 32'(i), 4'hF,
                  32'h0000_0500 + 32'(i * 4), 1'b1);
        chk("flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        store(32'h0000_0600, 32'h6666_6666, 4'hF, 32'h0000_0600, 1'b0);
        st_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_valid = (i % 2) == 1;
            #2;
            chk("flush_dm_we", 32'(dm_we), 32'((i % 2) == 0));
            chk("flush_st_ready", 32'(st_ready), 32'd0);
            tick();
        end
        chk("flush_empty", 32'(empty), 32'd1);
        flush = 1'b0;

        // Reset mid-operation discards buffered stores.
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++)
            store(32'h0000_0700 + 32'(i * 4), 32'h7700_0000 + 32'(i), 4'hF,
                  32'h0000_0700 + 32'(i * 4), 1'b1);
        st_valid = 1'b0;
        ld_valid = 1'b0;
        reset    = 1'b1;
        #2;
        chk("rst_mid_dm_we", 32'(dm_we), 32'd0);
        sb.delete();
        tick();
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_0704;
        #2;
        chk("rst_mid_empty", 32'(empty), 32'd1);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_fwd_mask", 32'(fwd_mask), 32'd0);
        ld_valid = 1'b0;
        repeat (3) tick();
        chk("sb_outstanding", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
